debug_serial_tx: RTL
====================

DEBUG_SERIAL_TX -- requirements
Module: debug_serial_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per serial bit (115200 baud at 100 MHz); legal values are 2 or more.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, giving the number of byte slots in the FIFO; legal values are powers of two, 2 or more.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port data_valid, input, 1 bit: push request for byte_data.
REQ-006 The block SHALL have port byte_data, input, 8 bits: byte to enqueue.
REQ-007 The block SHALL have port ready, output, 1 bit: high when the FIFO is not full.
REQ-008 The block SHALL have port tx, output, 1 bit: serial line, 8N1, idle high, registered.
REQ-009 The block SHALL have port busy, output, 1 bit: high while the serializer is not in IDLE or the FIFO is non-empty.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of each frame's stop bit.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky flag set when a push is dropped.
REQ-012 The block SHALL have port level, output, clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-013 Push: the block SHALL write byte_data at the tail on each edge where data_valid=1 and level<FIFO_DEPTH (pre-edge value), then increment level.
REQ-014 Full push: data_valid=1 with level==FIFO_DEPTH SHALL drop the byte and set overflow=1, even if a pop occurs on the same edge.
REQ-015 Pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
REQ-016 Simultaneous push and pop SHALL leave level unchanged.
REQ-017 ready SHALL be the combinational value (level != FIFO_DEPTH).
REQ-018 The serializer SHALL have states IDLE, START, DATA and STOP, plus a bit counter of 3 bits and a baud counter wide enough for CLKS_PER_BIT-1.
REQ-019 IDLE: tx=1; on an edge where pre-edge level>0, the block SHALL load the head byte into the shift register, pop it, set tx=0, clear the baud counter and enter START.
REQ-020 A byte pushed at edge N into an empty FIFO in IDLE SHALL be popped at edge N+1, with tx low from N+1.
REQ-021 Each of START, every DATA bit and STOP SHALL hold tx for exactly CLKS_PER_BIT cycles; the baud counter counts 0..CLKS_PER_BIT-1, and state/bit advances on the terminal count.
REQ-022 START→DATA: on the terminal count, tx SHALL be set to shift[0].
REQ-023 DATA: bits SHALL be sent LSB first; after bit 7's terminal count the block SHALL set tx=1 and enter STOP.
REQ-024 STOP terminal count: done=1 for that single cycle (registered, coincident with leaving STOP); if the FIFO is non-empty, the block SHALL pop, set tx=0 and enter START directly with no idle gap, otherwise it SHALL enter IDLE.
REQ-025 A full frame SHALL take 10*CLKS_PER_BIT cycles; back-to-back frames SHALL be contiguous.
REQ-026 busy SHALL be registered-state derived: (state != IDLE) or (level != 0).
REQ-027 overflow SHALL clear only on reset.

Reset
REQ-028 reset=1 SHALL immediately force state=IDLE, tx=1, done=0, busy=0, overflow=0, level=0, both pointers=0, and all counters=0; FIFO contents are don't-care.
REQ-029 Reset asserted mid-frame SHALL abort the frame, leaving tx high at once and queued bytes discarded.
REQ-030 Deassertion SHALL take effect at the first clk edge after reset falls; no push is accepted while reset=1.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 The bench SHALL check single byte: push 0xA5 at edge N -> tx low from N+1 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, stop high 4 cycles; done pulses once at N+40; busy low after.
REQ-032 The bench SHALL check back-to-back: push 0x55 then 0x0F on consecutive edges -> the second start bit immediately follows the first stop bit (no idle cycle), 80 cycles total, with two done pulses 40 cycles apart.
REQ-033 The bench SHALL check full/overflow: with the serializer busy, push 5 bytes 0x01..0x05 in one burst -> ready falls at level 4 (0x01 already popped); the 6th push 0x06 is dropped, overflow=1, and the bytes transmitted in order are 0x01..0x05.
REQ-034 The bench SHALL check simultaneous push/pop at full: level=4 at the STOP terminal count with a push on the same edge -> the push is dropped, overflow=1 and level=3.
REQ-035 The bench SHALL check reset mid-frame: assert reset during DATA bit 3 of 0xC3 with 2 bytes queued -> tx=1, level=0, busy=0 without waiting for a clk edge; a subsequent push of 0x7E transmits correctly.
REQ-036 The bench SHALL check pointer wrap: stream 10 bytes 0x30..0x39 while keeping the FIFO non-full -> all 10 bytes are received in order with no overflow.

Source files
------------

// File: rtl/debug_serial_tx.sv
// Byte FIFO feeding an 8N1 serial transmitter; frames are sent back to back while the FIFO holds
// data. Line idles high and every output except ready/busy is registered.
module debug_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        data_valid,
    input  logic [7:0]                  byte_data,
    output logic                        ready,
    output logic                        tx,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [7:0]        shift;
    logic [2:0]        bit_cnt;
    logic [BAUD_W-1:0] baud;
    logic              push;
    logic              pop;
    logic              baud_end;
    logic              fifo_nempty;

    assign fifo_nempty = (level != '0);
    assign ready       = (level != LVL_FULL);
    assign push        = data_valid && ready;
    assign baud_end    = (baud == BAUD_LAST);
    // The serializer takes the head byte from IDLE or straight out of the STOP terminal count.
    assign pop         = fifo_nempty && ((state == StIdle) || ((state == StStop) && baud_end));
    assign busy        = (state != StIdle) || fifo_nempty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= byte_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Fullness is judged on the pre-edge level, so a same-edge pop cannot rescue a push.
            if (data_valid && !ready) begin
                overflow <= 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= StIdle;
            tx      <= 1'b1;
            done    <= 1'b0;
            shift   <= '0;
            bit_cnt <= '0;
            baud    <= '0;
        end else begin
            // Raised one edge early so the pulse occupies the final cycle of the stop bit.
            done <= (state == StStop) && (baud == BAUD_PRE);
            unique case (state)
                StIdle: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        tx    <= 1'b0;
                        baud  <= '0;
                        state <= StStart;
                    end
                end
                StStart: begin
                    if (baud_end) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        tx      <= shift[0];
                        state   <= StData;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                StData: begin
                    if (baud_end) begin
                        baud  <= '0;
                        shift <= shift >> 1;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= StStop;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                StStop: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            tx    <= 1'b0;
                            state <= StStart;
                        end else begin
                            state <= StIdle;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
